// File: rtl/br_unit_pkg.sv
// br_unit_pkg: shared types for the branch/PC-relative execution unit
package br_unit_pkg;
  localparam int XW = 32;
  typedef enum logic [2:0] {
    INSTR_NONE,
    INSTR_AUIPC,
    INSTR_JAL,
    INSTR_JALR,
    INSTR_BRANCH
  } instr_op_t;
  typedef enum logic [1:0] {
    EXC_NONE,
    EXC_ILLEGAL,
    EXC_MISALIGNED_FETCH
  } exc_cause_t;
  typedef struct packed {
    instr_op_t       op;
    logic [2:0]      funct3;
    logic [XW-1:0]   pc;
    logic [XW-1:0]   imm;
    logic [XW-1:0]   rs1_val;
    logic [XW-1:0]   rs2_val;
    logic [4:0]      rd_idx;
    logic            compressed;
    logic            pred_taken;
    logic [XW-1:0]   pred_target;
  } brx_decoded;
  typedef struct packed {
    logic [4:0]    rd_idx;
    logic [XW-1:0] rd_val;
    logic          rd_we;
    logic          br_valid;
    logic [XW-1:0] br_target;
    logic          mispredict;
    logic          exc_valid;
    exc_cause_t    exc_cause;
  } brx_result;
endpackage

// File: rtl/br_unit_pipe_reg.sv
// br_unit_pipe_reg: one valid/ready register slice with flush
module br_unit_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= !flush && (in_ready ? in_valid : out_valid);
      if (in_ready && in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/br_unit.sv
// br_unit: resolves AUIPC/JAL/JALR/branches, checks prediction, pipelines result
module br_unit
  import br_unit_pkg::*;
#(
  parameter int XLEN   = XW,
  parameter int STAGES = 1,
  parameter int C_EXT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       decoded_valid,
  output logic       decoded_ready,
  input  brx_decoded decoded_data,
  output logic       result_valid,
  input  logic       result_ready,
  output brx_result  result
);
  localparam int W = $bits(brx_result);
  logic [XLEN-1:0] rs1, rs2, rel, jr_sum, tgt, link;
  logic [2:0] f3;
  logic is_auipc, is_jal, is_jalr, is_br, bad_f3, cond, taken, misal, illegal, exc;
  brx_result r;
  logic [W-1:0] pd [STAGES+1];
  logic [STAGES:0] pv, pr;
  assign rs1      = decoded_data.rs1_val;
  assign rs2      = decoded_data.rs2_val;
  assign f3       = decoded_data.funct3;
  assign is_auipc = decoded_data.op == INSTR_AUIPC;
  assign is_jal   = decoded_data.op == INSTR_JAL;
  assign is_jalr  = decoded_data.op == INSTR_JALR;
  assign is_br    = decoded_data.op == INSTR_BRANCH;
  assign rel      = decoded_data.pc + decoded_data.imm;
  assign jr_sum   = rs1 + decoded_data.imm;
  assign link     = decoded_data.pc + ((C_EXT != 0 && decoded_data.compressed) ? XLEN'(2) : XLEN'(4));
  assign tgt      = is_jalr ? (jr_sum & ~XLEN'(1)) : rel;
  // funct3[2:1] picks the comparison, funct3[0] inverts it
  assign bad_f3   = !f3[2] && f3[1];
  assign cond     = (f3[2] ? (f3[1] ? rs1 < rs2 : $signed(rs1) < $signed(rs2)) : rs1 == rs2) ^ f3[0];
  assign taken    = is_jal || is_jalr || (is_br && !bad_f3 && cond);
  assign misal    = taken && (C_EXT != 0 ? tgt[0] : tgt[1]);
  assign illegal  = !(is_auipc || is_jal || is_jalr || is_br) || (is_br && bad_f3);
  assign exc      = illegal || misal;
  always_comb begin
    r            = '0;
    r.rd_idx     = decoded_data.rd_idx;
    r.rd_val     = is_auipc ? rel : link;
    r.rd_we      = !exc && (is_auipc || ((is_jal || is_jalr) && decoded_data.rd_idx != '0));
    r.br_valid   = taken && !exc;
    r.br_target  = tgt;
    r.mispredict = !exc && ((taken != decoded_data.pred_taken) || (taken && tgt != decoded_data.pred_target));
    r.exc_valid  = exc;
    r.exc_cause  = illegal ? EXC_ILLEGAL : misal ? EXC_MISALIGNED_FETCH : EXC_NONE;
  end
  assign pv[0]         = decoded_valid;
  assign pd[0]         = r;
  assign pr[STAGES]    = result_ready;
  assign decoded_ready = pr[0];
  assign result_valid  = pv[STAGES];
  assign result        = brx_result'(pd[STAGES]);
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    br_unit_pipe_reg #(.W(W)) u_reg (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (pv[i]),
      .in_ready  (pr[i]),
      .in_data   (pd[i]),
      .out_valid (pv[i+1]),
      .out_ready (pr[i+1]),
      .out_data  (pd[i+1])
    );
  end
endmodule

// File: tb/tb_br_unit.sv
// tb_br_unit: directed checks of br_unit across three stage/C_EXT configurations
module tb_br_unit;
  import br_unit_pkg::*;
  logic clk = 0, rst = 1, flush = 0, v = 0, rr1 = 1, rr2 = 1, rr3 = 1;
  brx_decoded din = '0;
  logic rdy1, rdy2, rdy3, rv1, rv2, rv3;
  brx_result res1, res2, res3;
  int vecs = 0, miss = 0;
  always #5 clk = ~clk;
  br_unit #(.STAGES(1), .C_EXT(1)) u1 (.clk(clk), .rst(rst), .flush(flush), .decoded_valid(v),
    .decoded_ready(rdy1), .decoded_data(din), .result_valid(rv1), .result_ready(rr1), .result(res1));
  br_unit #(.STAGES(2), .C_EXT(0)) u2 (.clk(clk), .rst(rst), .flush(flush), .decoded_valid(v),
    .decoded_ready(rdy2), .decoded_data(din), .result_valid(rv2), .result_ready(rr2), .result(res2));
  br_unit #(.STAGES(3), .C_EXT(0)) u3 (.clk(clk), .rst(rst), .flush(flush), .decoded_valid(v),
    .decoded_ready(rdy3), .decoded_data(din), .result_valid(rv3), .result_ready(rr3), .result(res3));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic brx_decoded mk(input instr_op_t op, input logic [2:0] f3,
      input logic [31:0] pc, imm, rs1, rs2, input logic [4:0] rd, input logic c, pt,
      input logic [31:0] ptgt);
    brx_decoded d;
    d.op = op;
    d.funct3 = f3;
    d.pc = pc;
    d.imm = imm;
    d.rs1_val = rs1;
    d.rs2_val = rs2;
    d.rd_idx = rd;
    d.compressed = c;
    d.pred_taken = pt;
    d.pred_target = ptgt;
    return d;
  endfunction
  task automatic send(input brx_decoded d);
    @(negedge clk);
    din = d;
    v = 1;
    @(negedge clk);
    v = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_valid", 64'({rv1, rv2, rv3}), 0);
    chk("rst_ready", 64'({rdy1, rdy2, rdy3}), 'b111);
    chk("rst_res", 64'(res1 == '0 && res2 == '0 && res3 == '0), 1);
    send(mk(INSTR_BRANCH, 3'b101, 'h100, 'h20, '1, '1, 0, 0, 0, 0));
    chk("bge_lat", 64'(rv2), 0);
    @(negedge clk);
    chk("bge_valid", 64'(rv2), 1);
    chk("bge_br", 64'(res2.br_valid), 1);
    chk("bge_tgt", 64'(res2.br_target), 'h120);
    chk("bge_mp", 64'(res2.mispredict), 1);
    send(mk(INSTR_JAL, 3'b000, 'h200, 6, 0, 0, 1, 1, 1, 'h206));
    chk("cjal_link", 64'(res1.rd_val), 'h202);
    chk("cjal_tgt", 64'(res1.br_target), 'h206);
    chk("cjal_we", 64'(res1.rd_we), 1);
    chk("cjal_exc", 64'(res1.exc_valid), 0);
    chk("cjal_mp", 64'(res1.mispredict), 0);
    @(negedge clk);
    chk("cjal_nc_cause", 64'(res2.exc_cause), 64'(EXC_MISALIGNED_FETCH));
    chk("cjal_nc_we", 64'(res2.rd_we), 0);
    chk("cjal_nc_exc", 64'(res2.exc_valid), 1);
    send(mk(INSTR_JALR, 3'b000, 'h100, 0, 'h1001, 0, 5, 0, 1, 'h1000));
    @(negedge clk);
    chk("jalr_tgt", 64'(res2.br_target), 'h1000);
    chk("jalr_mp", 64'(res2.mispredict), 0);
    chk("jalr_link", 64'(res2.rd_val), 'h104);
    chk("jalr_we", 64'(res2.rd_we), 1);
    send(mk(INSTR_BRANCH, 3'b110, 'h300, 'h10, '1, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("bltu_br", 64'(res2.br_valid), 0);
    chk("bltu_tgt", 64'(res2.br_target), 'h310);
    chk("bltu_mp", 64'(res2.mispredict), 0);
    send(mk(INSTR_BRANCH, 3'b010, 'h300, 'h10, 1, 1, 0, 0, 1, 'h310));
    @(negedge clk);
    chk("f3_010_cause", 64'(res2.exc_cause), 64'(EXC_ILLEGAL));
    chk("f3_010_br", 64'(res2.br_valid), 0);
    chk("f3_010_mp", 64'(res2.mispredict), 0);
    send(mk(INSTR_BRANCH, 3'b100, 'h400, 'hFFFF_FFF8, '1, 1, 0, 0, 1, 'h3F0));
    @(negedge clk);
    chk("blt_br", 64'(res2.br_valid), 1);
    chk("blt_tgt", 64'(res2.br_target), 'h3F8);
    chk("blt_mp", 64'(res2.mispredict), 1);
    send(mk(INSTR_BRANCH, 3'b000, 'h400, 8, 5, 6, 0, 0, 0, 0));
    @(negedge clk);
    chk("beq_br", 64'(res2.br_valid), 0);
    chk("beq_mp", 64'(res2.mispredict), 0);
    send(mk(INSTR_AUIPC, 3'b000, 'h1000, 'h1234_5000, 0, 0, 3, 0, 0, 0));
    @(negedge clk);
    chk("auipc_val", 64'(res2.rd_val), 'h1234_6000);
    chk("auipc_we", 64'(res2.rd_we), 1);
    chk("auipc_br", 64'(res2.br_valid), 0);
    chk("auipc_exc", 64'(res2.exc_valid), 0);
    send(mk(INSTR_JAL, 3'b000, 'h100, 'h40, 0, 0, 0, 0, 1, 'h140));
    @(negedge clk);
    chk("jal_x0_we", 64'(res2.rd_we), 0);
    chk("jal_x0_tgt", 64'(res2.br_target), 'h140);
    chk("jal_x0_mp", 64'(res2.mispredict), 0);
    send(mk(INSTR_NONE, 3'b000, 'h100, 0, 0, 0, 2, 0, 0, 0));
    @(negedge clk);
    chk("badop_cause", 64'(res2.exc_cause), 64'(EXC_ILLEGAL));
    chk("badop_we", 64'(res2.rd_we), 0);
    repeat (4) @(negedge clk);
    rr3 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      din = mk(INSTR_JAL, 3'b000, 32'(16 * (k + 1)), 0, 0, 0, 1, 0, 0, 0);
      v = 1;
      chk("full_ready", 64'(rdy3), 64'(k < 3));
    end
    @(negedge clk);
    v = 0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk("drain_valid", 64'(rv3), 1);
      chk("drain_tgt", 64'(res3.br_target), 64'(16 * (j + 1)));
      rr3 = 1;
      @(negedge clk);
    end
    chk("drain_end", 64'(rv3), 0);
    @(negedge clk);
    din = mk(INSTR_JAL, 3'b000, 'h500, 0, 0, 0, 1, 0, 0, 0);
    v = 1;
    @(negedge clk);
    din = mk(INSTR_JAL, 3'b000, 'h600, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    din = mk(INSTR_JAL, 3'b000, 'h700, 0, 0, 0, 1, 0, 0, 0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    v = 0;
    chk("flush_valid", 64'({rv1, rv2, rv3}), 0);
    repeat (4) begin
      @(negedge clk);
      chk("flush_stale", 64'({rv1, rv2, rv3}), 0);
    end
    rr2 = 0;
    rr3 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      din = mk(INSTR_BRANCH, 3'b101, 'h100, 'h20, '1, '1, 0, 0, 0, 0);
      v = 1;
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    v = 0;
    chk("mrst_valid", 64'({rv1, rv2, rv3}), 0);
    chk("mrst_ready", 64'({rdy1, rdy2, rdy3}), 'b111);
    chk("mrst_res", 64'(res1 == '0 && res2 == '0 && res3 == '0), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/br_unit.md
# br_unit

Parametrised PC-relative and branch execution unit for the integer execute stage. It is the successor of the single-cycle combinational `misc` unit. It resolves AUIPC, JAL, JALR and conditional branches, and checks the outcome against the front-end prediction. It reports mispredicts and invalid or misaligned control transfers. It holds results in a configurable-depth pipeline with full valid/ready backpressure and flush.

## Interface
Parameters:
- `XLEN`, 32: operand/address width.
- `STAGES`, 1: register stages between input handshake and result (legal 1..3).
- `C_EXT`, 0: 1 enables 16-bit instructions. Link step becomes 2 for compressed ops; the alignment check becomes 2-byte.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline kill.
- `decoded`  decoupled.in  —  `valid`/`ready`/`data`; data adds `compressed`, `pred_taken`, `pred_target` to existing decoded fields.
- `result_valid`  out  1  result slot holds a live result.
- `result_ready`  in  1  consumer accepts result this cycle.
- `result`  out  `brx_result`  fields: `rd_idx`, `rd_val`, `rd_we`, `br_valid`, `br_target`, `mispredict`, `exc_valid`, `exc_cause`.

## Operation
- `rel = pc + imm`, modulo 2^XLEN; `jr = (rs1_val + imm) & ~1`.
- Link value: `pc + (C_EXT && compressed ? 2 : 4)`.
- AUIPC: `rd_val = rel`, `rd_we = 1`, `br_valid = 0`, no exception.
- JAL: `br_valid = 1`, target `rel`, `rd_val` = link, `rd_we = (rd != 0)`.
- JALR: same as JAL with target `jr`.
- Branch, decided by funct3; `rd_we = 0`, `br_target = rel`:
  - 000 EQ; 001 NE.
  - 100 LT signed; 101 GE signed (`>=`, not `>`).
  - 110 LTU; 111 GEU (`>=`).
  - 010 and 011 raise `exc_cause = ILLEGAL`, `br_valid = 0`.
- Misalignment: a taken target with `target[1] = 1` when `C_EXT = 0` (or `target[0]` when `C_EXT = 1`) raises `exc_cause = MISALIGNED_FETCH`. On any exception: `rd_we = 0`, `mispredict = 0`.
- Any other `op` raises `exc_cause = ILLEGAL`.
- `mispredict = (br_valid != pred_taken) || (br_valid && br_target != pred_target)`.
- Pipeline: stage i holds `vld[i]` and payload.
  - `rdy[i] = !vld[i] || rdy[i+1]`; `rdy[STAGES] = result_ready`.
  - `decoded.ready = rdy[0]`.
  - Compute happens combinationally before stage 0 is written. Later stages move data only.

## Timing
- Reset: all `vld` = 0, `result_valid = 0`, all `result` fields 0, `decoded.ready = 1` in the first cycle after reset.
- Latency: a beat accepted in cycle t appears with `result_valid = 1` in cycle t+STAGES if not stalled.
- Throughput: 1 result per cycle when `result_ready` is held high.
- Stall: when `result_valid && !result_ready`, `result` holds stable; bubbles upstream compress.
- Full: all stages valid and `result_ready = 0` gives `decoded.ready = 0`.
- Flush: all `vld` clear at the next edge. A beat handshaken in the flush cycle is discarded. `result_valid` is 0 the cycle after flush. The flush cycle itself still shows the old result, and the consumer must ignore it.
- Flush and reset together: reset wins; the outcome is identical.
- Reset mid-stall: all in-flight results are lost with no handshake.

## Structure
- Shared package (`types.sv`) holds:
  - `brx_result` struct;
  - `exc_cause_t` enum with `EXC_NONE`, `EXC_ILLEGAL`, `EXC_MISALIGNED_FETCH`;
  - `INSTR_JALR` added to the op enum.
- One sub-module, `pipe_reg`: a parametrised-payload valid/ready register slice, instantiated STAGES times in a generate loop. The resolve logic stays in `br_unit`.

## Test plan
- STAGES=2, C_EXT=0, result_ready=1: BGE with rs1=-1, rs2=-1, pc=0x100, imm=0x20, pred_taken=0 → after 2 cycles `br_valid=1`, `br_target=0x120`, `mispredict=1`.
- C_EXT=1: compressed JAL at pc=0x200, imm=6, rd=1 → `rd_val=0x202`, `br_target=0x206`, `rd_we=1`, no exception. Same stimulus with C_EXT=0 → `exc_cause=MISALIGNED_FETCH`, `rd_we=0`.
- JALR with rs1=0x1001, imm=0 → `br_target=0x1000`. BLTU with 0xFFFFFFFF vs 1 → not taken. Branch funct3=010 → `exc_cause=ILLEGAL`.
- STAGES=3: hold `result_ready=0` and push 4 beats → exactly 3 accepted, 4th sees `decoded.ready=0`. Release → results in order with unchanged values.
- Assert flush while 2 beats are in flight and a 3rd is handshaking → `result_valid=0` the next cycle and no stale result ever appears.
- Pulse `rst` mid-stream → all outputs 0 the next cycle and `decoded.ready=1`.
